// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory req/ack port between fetch stage and imem
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch stage with IF/ID register and skid buffer
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master imem,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          id_valid,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_pc4,
  output logic [31:0]   id_inst,
  output logic [5:0]    id_op,
  output logic [4:0]    id_rs,
  output logic [4:0]    id_rt,
  output logic [4:0]    id_rd,
  output logic [4:0]    id_shamt,
  output logic [5:0]    id_func,
  output logic [15:0]   id_imm
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] DROP  = 2'd1;
  localparam logic [1:0] BUF   = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] tgt;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;
  logic        run;
  logic        free;
  logic [31:0] rpc;

  // run holds the request low for the first cycle after reset release
  assign free           = !id_valid || !stall;
  assign rpc            = {redirect_pc[31:2], 2'b00};
  assign imem.imem_req  = run && ((state == FETCH) || (state == DROP));
  assign imem.imem_addr = {pc[31:2], 2'b00};

  assign id_pc4   = id_pc + 32'd4;
  assign id_op    = id_inst[31:26];
  assign id_rs    = id_inst[25:21];
  assign id_rt    = id_inst[20:16];
  assign id_rd    = id_inst[15:11];
  assign id_shamt = id_inst[10:6];
  assign id_func  = id_inst[5:0];
  assign id_imm   = id_inst[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      tgt      <= RESET_PC;
      buf_inst <= 32'h0;
      buf_pc   <= RESET_PC;
      run      <= 1'b0;
      id_valid <= 1'b0;
      id_inst  <= 32'h0;
      id_pc    <= RESET_PC;
    end else begin
      run <= 1'b1;
      if (run) begin
        case (state)
          FETCH: begin
            if (redirect) begin
              id_valid <= 1'b0;
              if (imem.imem_ack) begin
                pc <= rpc;
              end else begin
                tgt   <= rpc;
                state <= DROP;
              end
            end else if (imem.imem_ack) begin
              pc <= pc + 32'd4;
              if (free) begin
                id_inst  <= imem.imem_rdata;
                id_pc    <= pc;
                id_valid <= 1'b1;
              end else begin
                buf_inst <= imem.imem_rdata;
                buf_pc   <= pc;
                state    <= BUF;
              end
            end else if (free) begin
              id_valid <= 1'b0;
            end
          end
          DROP: begin
            // the outstanding request must complete before the target is fetched
            id_valid <= 1'b0;
            if (redirect) begin
              tgt <= rpc;
            end
            if (imem.imem_ack) begin
              pc    <= redirect ? rpc : tgt;
              state <= FETCH;
            end
          end
          BUF: begin
            if (redirect) begin
              id_valid <= 1'b0;
              pc       <= rpc;
              state    <= FETCH;
            end else if (!stall) begin
              id_inst  <= buf_inst;
              id_pc    <= buf_pc;
              id_valid <= 1'b1;
              state    <= FETCH;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  int          passed = 0;
  int          total = 0;

  always #5 clk = ~clk;

  fetch_stage_if bus ();
  fetch_stage_if wbus ();

  logic        id_valid, w_id_valid;
  logic [31:0] id_pc, id_pc4, id_inst, w_id_pc, w_id_pc4, w_id_inst;
  logic [5:0]  id_op, id_func, w_id_op, w_id_func;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt, w_id_rs, w_id_rt, w_id_rd, w_id_shamt;
  logic [15:0] id_imm, w_id_imm;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4),
    .id_inst(id_inst), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_func(id_func), .id_imm(id_imm)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem(wbus), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_valid(w_id_valid), .id_pc(w_id_pc), .id_pc4(w_id_pc4),
    .id_inst(w_id_inst), .id_op(w_id_op), .id_rs(w_id_rs), .id_rt(w_id_rt), .id_rd(w_id_rd),
    .id_shamt(w_id_shamt), .id_func(w_id_func), .id_imm(w_id_imm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    wbus.imem_ack  = 1'b0;
    wbus.imem_rdata = 32'h0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // one zero-wait fetch: memory acks the current address with addr|0x0C000000
  task automatic zw();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = bus.imem_addr | 32'h0C00_0000;
    tick();
    bus.imem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", bus.imem_req); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", id_valid); else passed++;
    total++; if (id_inst !== 32'h0) $display("FAIL rst_inst got %h want 0", id_inst); else passed++;
    total++; if (id_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", id_pc); else passed++;
    total++; if (w_id_pc !== 32'hFFFF_FFFC) $display("FAIL rst_wpc got %h want fffffffc", w_id_pc); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.imem_req !== 1'b0) $display("FAIL rel_req got %b want 0", bus.imem_req); else passed++;
    tick();
    total++; if (bus.imem_req !== 1'b1) $display("FAIL first_req got %b want 1", bus.imem_req); else passed++;
    total++; if (bus.imem_addr !== 32'h0) $display("FAIL first_addr got %h want 0", bus.imem_addr); else passed++;
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      zw();
      total++; if (id_valid !== 1'b1) $display("FAIL zw_valid%0d got %b want 1", i, id_valid); else passed++;
      total++; if (id_pc !== 32'(4 * i)) $display("FAIL zw_pc%0d got %h want %h", i, id_pc, 32'(4 * i)); else passed++;
      total++; if (id_pc4 !== 32'(4 * i + 4)) $display("FAIL zw_pc4%0d got %h want %h", i, id_pc4, 32'(4 * i + 4)); else passed++;
      total++; if (id_op !== 6'h03) $display("FAIL zw_op%0d got %h want 03", i, id_op); else passed++;
      total++; if (id_inst !== (32'h0C00_0000 | 32'(4 * i))) $display("FAIL zw_inst%0d got %h want %h", i, id_inst, 32'h0C00_0000 | 32'(4 * i)); else passed++;
    end
  endtask

  task automatic test_latency();
    do_reset();
    zw();
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 3; k++) begin
        total++; if (bus.imem_addr !== 32'(4 * rep + 4) || bus.imem_req !== 1'b1)
          $display("FAIL lat_addr r%0d k%0d got %h/%b want %h/1", rep, k, bus.imem_addr, bus.imem_req, 32'(4 * rep + 4));
        else passed++;
        bus.imem_ack   = (k == 2);
        bus.imem_rdata = 32'h0C00_0000 | 32'(4 * rep + 4);
        tick();
        bus.imem_ack   = 1'b0;
        total++; if (id_valid !== (k == 2)) $display("FAIL lat_valid r%0d k%0d got %b want %b", rep, k, id_valid, (k == 2)); else passed++;
      end
      total++; if (id_pc !== 32'(4 * rep + 4)) $display("FAIL lat_pc r%0d got %h want %h", rep, id_pc, 32'(4 * rep + 4)); else passed++;
    end
  endtask

  task automatic test_stall_buf();
    do_reset();
    zw();
    zw();
    stall          = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0085_1020;
    tick();
    bus.imem_ack   = 1'b0;
    total++; if (id_pc !== 32'h4 || id_valid !== 1'b1) $display("FAIL buf_hold1 got %h/%b want 00000004/1", id_pc, id_valid); else passed++;
    total++; if (bus.imem_req !== 1'b0) $display("FAIL buf_req1 got %b want 0", bus.imem_req); else passed++;
    tick();
    total++; if (id_pc !== 32'h4) $display("FAIL buf_hold2 got %h want 00000004", id_pc); else passed++;
    total++; if (bus.imem_req !== 1'b0) $display("FAIL buf_req2 got %b want 0", bus.imem_req); else passed++;
    stall = 1'b0;
    tick();
    total++; if (id_inst !== 32'h0085_1020) $display("FAIL buf_inst got %h want 00851020", id_inst); else passed++;
    total++; if (id_pc !== 32'h8) $display("FAIL buf_pc got %h want 00000008", id_pc); else passed++;
    total++; if (id_func !== 6'h20) $display("FAIL buf_func got %h want 20", id_func); else passed++;
    total++; if (id_rd !== 5'd2) $display("FAIL buf_rd got %h want 02", id_rd); else passed++;
    total++; if (id_rs !== 5'd4 || id_rt !== 5'd5) $display("FAIL buf_rsrt got %h/%h want 04/05", id_rs, id_rt); else passed++;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) $display("FAIL buf_next got %b/%h want 1/0000000c", bus.imem_req, bus.imem_addr); else passed++;
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (4) zw();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    total++; if (id_valid !== 1'b0) $display("FAIL redir_valid got %b want 0", id_valid); else passed++;
    total++; if (bus.imem_addr !== 32'h10 || bus.imem_req !== 1'b1) $display("FAIL redir_hold1 got %h/%b want 00000010/1", bus.imem_addr, bus.imem_req); else passed++;
    tick();
    total++; if (bus.imem_addr !== 32'h10 || id_valid !== 1'b0) $display("FAIL redir_hold2 got %h/%b want 00000010/0", bus.imem_addr, id_valid); else passed++;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_0010;
    tick();
    bus.imem_ack   = 1'b0;
    total++; if (id_valid !== 1'b0) $display("FAIL redir_drop got %b want 0", id_valid); else passed++;
    total++; if (bus.imem_addr !== 32'h100) $display("FAIL redir_addr got %h want 00000100", bus.imem_addr); else passed++;
    zw();
    total++; if (id_pc !== 32'h100 || id_inst !== 32'h0C00_0100) $display("FAIL redir_first got %h/%h want 00000100/0c000100", id_pc, id_inst); else passed++;
  endtask

  task automatic test_redirect_stall_ack();
    do_reset();
    zw();
    zw();
    redirect       = 1'b1;
    stall          = 1'b1;
    redirect_pc    = 32'h203;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1111_1111;
    tick();
    idle_inputs();
    total++; if (id_valid !== 1'b0) $display("FAIL rsa_valid got %b want 0", id_valid); else passed++;
    total++; if (bus.imem_addr !== 32'h200 || bus.imem_req !== 1'b1) $display("FAIL rsa_addr got %h/%b want 00000200/1", bus.imem_addr, bus.imem_req); else passed++;
    zw();
    total++; if (id_pc !== 32'h200 || id_inst !== 32'h0C00_0200) $display("FAIL rsa_first got %h/%h want 00000200/0c000200", id_pc, id_inst); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    total++; if (wbus.imem_addr !== 32'hFFFF_FFFC || wbus.imem_req !== 1'b1) $display("FAIL wrap_addr0 got %h/%b want fffffffc/1", wbus.imem_addr, wbus.imem_req); else passed++;
    wbus.imem_ack   = 1'b1;
    wbus.imem_rdata = 32'h0C00_00FC;
    tick();
    wbus.imem_ack   = 1'b0;
    total++; if (w_id_pc !== 32'hFFFF_FFFC || w_id_valid !== 1'b1) $display("FAIL wrap_pc got %h/%b want fffffffc/1", w_id_pc, w_id_valid); else passed++;
    total++; if (w_id_pc4 !== 32'h0) $display("FAIL wrap_pc4 got %h want 00000000", w_id_pc4); else passed++;
    total++; if (wbus.imem_addr !== 32'h0) $display("FAIL wrap_addr1 got %h want 00000000", wbus.imem_addr); else passed++;
  endtask

  task automatic test_reset_mid_drop();
    do_reset();
    zw();
    zw();
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) $display("FAIL drop_pre got %b/%h want 1/00000008", bus.imem_req, bus.imem_addr); else passed++;
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (bus.imem_req !== 1'b0) $display("FAIL arst_req got %b want 0", bus.imem_req); else passed++;
    total++; if (id_pc !== 32'h0 || id_valid !== 1'b0 || id_inst !== 32'h0) $display("FAIL arst_id got %h/%b/%h want 0/0/0", id_pc, id_valid, id_inst); else passed++;
    total++; if (bus.imem_addr !== 32'h0) $display("FAIL arst_addr got %h want 00000000", bus.imem_addr); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL arst_restart got %b/%h want 1/00000000", bus.imem_req, bus.imem_addr); else passed++;
    zw();
    total++; if (id_pc !== 32'h0 || id_valid !== 1'b1) $display("FAIL arst_first got %h/%b want 00000000/1", id_pc, id_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall_buf();
    test_redirect();
    test_redirect_stall_ack();
    test_wrap();
    test_reset_mid_drop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
